rr_arb32: RTL
=============

// Module: rr_arb32
//
// PURPOSE
//   Round-robin arbiter that shares one 32-way resource, selected through the
//   5-to-32 one-hot decode, among 32 requesters.
//   - Picks one requester and registers its 5-bit index.
//   - Drives the decoded one-hot grant from that index.
//   - Holds the grant until the owner releases it, then rotates priority.
//   - Sits between the requester array and the decode/select datapath.
//
// PARAMETERS
//   N        32  number of requesters (fixed 32; index width must match)
//   IDXW     5   grant index width, log2(N)
//   TIMEOUT  16  max cycles a grant may be held (used only with ARB_TIMEOUT_EN), >=2
//
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous reset, active low
//   req        in   32    request vector, bit i = requester i
//   done       in   1     owner release strobe, sampled only while granting
//   gnt        out  32    one-hot grant = decode(gnt_idx) when gnt_valid, else 0
//   gnt_idx    out  5     index of current/last owner
//   gnt_valid  out  1     grant active
//   timeout    out  1     1-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0,
//     ptr=0, timeout=0, hold counter=0. Takes effect immediately, including
//     mid-grant; the grant drops without waiting for a clock edge.
//   - gnt is a combinational decode of the registered gnt_idx, gated by gnt_valid.
//   - FSM, 2 states:
//     - IDLE: if |req, select the first set bit searching upward from ptr, with
//       wrap 31->0. Register gnt_idx and set gnt_valid; go to GRANT.
//       If req==0, stay in IDLE.
//     - GRANT: stay while req[gnt_idx]=1 and done=0.
//       Release when done=1 or req[gnt_idx]=0: clear gnt_valid, set
//       ptr=gnt_idx+1 (mod 32, so 31 wraps to 0), go to IDLE. gnt_idx keeps
//       the last owner.
//   - Latency:
//     - Request sampled in IDLE -> gnt valid on the next edge (1 cycle).
//     - Release condition -> gnt=0 on the next edge.
//     - Minimum one IDLE cycle between consecutive grants; no direct handoff.
//   - Priority: ptr holds the highest priority. The just-served requester
//     becomes lowest priority, so no requester starves while it holds req.
//   - Simultaneous events:
//     - done and a req change in the same cycle: treated as one release.
//     - done while in IDLE: ignored.
//     - Requests other than the owner's are ignored while in GRANT.
//   - Only gnt_idx and gnt_valid are registered; gnt is never multi-hot.
//
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - A hold counter clears on grant and increments every GRANT cycle.
//     - When the counter reaches TIMEOUT-1 with no release, the arbiter forces
//       a release, pulses timeout=1 for one cycle, and advances ptr as a
//       normal release.
//     - A normal release in the same cycle takes precedence: timeout stays 0.
//   ARB_TIMEOUT_EN undefined:
//     - No counter; timeout is tied to 0.
//     - A grant is held indefinitely until done or req drop.
//
// TESTING
//   1 rst_n=0 with req=32'hFFFF_FFFF -> gnt=0, gnt_idx=0, gnt_valid=0 throughout reset
//   2 after reset req=32'h0000_0020 -> next edge gnt=32'h0000_0020, gnt_idx=5;
//     done pulse -> next edge gnt=0, gnt_idx stays 5
//   3 req=32'h8000_0011 held, done pulsed each grant -> grant order idx 0,4,31,0;
//     one idle cycle between grants
//   4 wrap: after grant idx 31 released, req=32'h8000_0004 -> next grant idx 2
//     (ptr=0), not 31
//   5 rst_n dropped mid-cycle while gnt=32'h0000_0008 -> gnt=0 immediately;
//     after release, req[3] -> grant idx 3
//   6 ARB_TIMEOUT_EN, TIMEOUT=16: req[3] held, done=0 -> gnt high 16 cycles,
//     then timeout=1 for one cycle, gnt=0; the next grant goes to the next
//     requester above 3

Source files
------------

// File: rtl/rr_arb32.sv
// rr_arb32: 32-way round-robin arbiter with registered grant index and one-hot decode.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; searches upward from ptr for the next requester
// GRANT | owner gnt_idx holds the resource until done or its req drops
module rr_arb32 #(
    parameter int N       = 32,
    parameter int IDXW    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] gnt_idx_q;
    logic            gnt_valid_q;
    logic [IDXW-1:0] ptr_q;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cand;
    logic            release_w;
    logic            force_w;

    // First set request at or above ptr; the IDXW-bit add wraps 31 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + IDXW'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign release_w = done || !req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNTW-1:0] hold_cnt_q;
    logic            timeout_q;

    assign force_w = (hold_cnt_q == CNTW'(TIMEOUT - 1));
    assign timeout = timeout_q;
`else
    assign force_w = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        state_q     <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_w || force_w) begin
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_idx_q + 1'b1;
                        state_q     <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        // A voluntary release in the same cycle wins: no pulse.
                        timeout_q   <= !release_w;
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt       = gnt_valid_q ? (N'(1) << gnt_idx_q) : '0;

endmodule
